int_to_fp: RTL and testbench

- Multi-cycle converter from a signed two's-complement sample to IEEE-754 single precision.
- Sits directly upstream of fpadd: it turns fixed-point oscillator/voice samples into the float operands that fpadd sums.
- Normalisation is iterative, one bit shift per clock, for small area on the FPGA.
- Start/done handshake. The result is exact (no rounding) because WIDTH <= 24.

---
 rtl/int_to_fp.sv | 85 ++++++++
 tb/tb_int_to_fp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/int_to_fp.sv
// Converts a signed two's-complement sample to an IEEE-754 single-precision float.
// Normalisation shifts the magnitude left one bit per clock; the result is exact because WIDTH <= 24.
module int_to_fp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [31:0]      result,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_PACK
  } state_t;

  // Exponent of a value whose leading one sits in the top bit of the sample.
  localparam logic [7:0] EXP_INIT = 8'(127 + WIDTH - 1);

  state_t           r_state;
  logic             r_sign;
  logic             r_zero;
  logic [WIDTH-1:0] r_mag;
  logic [7:0]       r_exp;
  logic [31:0]      r_result;
  logic             r_done;

  logic [WIDTH-1:0] w_mag_in;
  logic [22:0]      w_frac;

  // The most-negative sample negates to 2^(WIDTH-1), which still fits unsigned.
  assign w_mag_in = data[WIDTH-1] ? -data : data;

  // The implicit leading one is dropped; the remaining bits are left-justified.
  assign w_frac = 23'(r_mag[WIDTH-2:0]) << (24 - WIDTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_mag    <= '0;
      r_exp    <= '0;
      r_result <= 32'h0000_0000;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every branch reads the pre-edge values of r_mag/r_exp.
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sign  <= data[WIDTH-1];
            r_mag   <= w_mag_in;
            r_exp   <= EXP_INIT;
            r_zero  <= (data == '0);
            r_done  <= 1'b0;
            r_state <= (data == '0) ? ST_PACK : ST_NORM;
          end
        end
        ST_NORM: begin
          if (r_mag[WIDTH-1]) begin
            r_state <= ST_PACK;
          end else begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        ST_PACK: begin
          r_result <= r_zero ? 32'h0000_0000 : {r_sign, r_exp, w_frac};
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready  = (r_state == ST_IDLE);
  assign result = r_result;
  assign done   = r_done;

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: directed test-plan vectors plus random samples
// compared against an arithmetic float-encoding model.
module tb_int_to_fp;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic [31:0]      result;
  logic             done;

  int tests;
  int fails;

  int_to_fp #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data   (data),
    .ready  (ready),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Position of the most significant set bit of a positive integer.
  function automatic int msb_pos(input int a);
    int e;
    e = 0;
    while ((a >> (e + 1)) != 0) e++;
    return e;
  endfunction

  // IEEE-754 single encoding of an integer, built from sign/exponent/fraction rules.
  function automatic logic [31:0] ref_fp(input int v);
    int   a;
    int   e;
    logic s;
    if (v == 0) return 32'h0000_0000;
    s = (v < 0);
    a = s ? -v : v;
    e = msb_pos(a);
    return {s, 8'(127 + e), 23'((a << (23 - e)) & 32'h007f_ffff)};
  endfunction

  // Edges from acceptance to done: 1 for zero, otherwise leading zeros + 2.
  function automatic int ref_lat(input int v);
    int a;
    if (v == 0) return 1;
    a = (v < 0) ? -v : v;
    return (WIDTH - 1 - msb_pos(a)) + 2;
  endfunction

  // Issue one conversion and check latency and result. When inject is set, a
  // stray start with a different sample is pulsed while the conversion runs.
  task automatic do_conv(input string tag, input logic [WIDTH-1:0] d,
                         input logic [31:0] exp_res, input int exp_lat, input bit inject);
    int edges;
    @(negedge clk);
    check({tag, "/ready_before"}, {31'd0, ready}, 32'd1);
    start = 1'b1;
    data  = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = WIDTH'($urandom);
    check({tag, "/ready_after_accept"}, {31'd0, ready}, 32'd0);
    check({tag, "/done_cleared"}, {31'd0, done}, 32'd0);
    edges = 0;
    while (!done && edges < 40) begin
      if (inject && edges == 2) begin
        start = 1'b1;
        data  = 16'h7fff;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
    check({tag, "/latency"}, 32'(edges), 32'(exp_lat));
    check({tag, "/result"}, result, exp_res);
    check({tag, "/ready_done"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    logic [31:0]      held;
    int               edges;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    start = 1'b0;
    data  = '0;

    #1;
    check("reset/result", result, 32'h0000_0000);
    check("reset/done", {31'd0, done}, 32'd0);
    check("reset/ready", {31'd0, ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_conv("pos_one",  16'h0001, 32'h3f80_0000, 17, 1'b0);
    do_conv("neg_one",  16'hffff, 32'hbf80_0000, 17, 1'b0);
    do_conv("twelve",   16'h000c, 32'h4140_0000, 14, 1'b0);
    do_conv("p16384",   16'h4000, 32'h4680_0000, 3,  1'b0);
    do_conv("most_neg", 16'h8000, 32'hc700_0000, 2,  1'b0);
    do_conv("zero",     16'h0000, 32'h0000_0000, 1,  1'b0);
    do_conv("ignored_start", 16'h0003, 32'h4040_0000, 16, 1'b1);

    // Idle with start low: done and result must hold.
    held = result;
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold/done", {31'd0, done}, 32'd1);
    check("idle_hold/result", result, held);

    // Back-to-back: second start lands on the first edge after done rises.
    do_conv("b2b_first",  16'h0003, 32'h4040_0000, 16, 1'b0);
    do_conv("b2b_second", 16'hfffd, 32'hc040_0000, 16, 1'b0);

    // Asynchronous reset in the middle of normalisation.
    @(negedge clk);
    start = 1'b1;
    data  = 16'h0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset/done", {31'd0, done}, 32'd0);
    check("midreset/result", result, 32'h0000_0000);
    check("midreset/ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    // Nothing may emerge from the discarded conversion.
    edges = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) edges++;
    end
    check("midreset/no_stale_done", 32'(edges), 32'd0);
    do_conv("after_reset", 16'h0003, 32'h4040_0000, 16, 1'b0);

    // Random samples against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rv = WIDTH'($urandom);
      if (i % 4 == 1) rv = WIDTH'($urandom_range(0, 31));
      if (i % 4 == 2) rv = -WIDTH'($urandom_range(1, 31));
      do_conv($sformatf("rand%0d_%h", i, rv), rv,
              ref_fp(int'($signed(rv))), ref_lat(int'($signed(rv))), (i % 5 == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
